// File: rtl/line_mem_responder.sv
// line_mem_responder: main-memory model at the far end of the cache refill/writeback path.
// Queues 128-bit line read/write requests in order and serves them one at a time. Each access
// takes MEM_DELAY_CYCLES cycles. The response is returned with a valid/ready handshake.
// The backing store is the 32-bit word array `data`. Reset does not clear it, so a preload
// survives reset.
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   req_valid/ready    request handshake; req_ready is low while the queue is full
//   req_write          1 = line write, 0 = line read
//   req_addr           byte address; line index = req_addr[31:4]
//   req_wdata/wmask    write line (word 0 = bits [31:0]) and per-word enable
//   req_id             requester tag, echoed on resp_id
//   resp_valid/ready   response handshake
//   resp_rdata         read line; 0 for writes and errors
//   resp_id/resp_err   echoed tag; line index out of range
module line_mem_responder #(
  parameter int unsigned MEM_WORDS        = 4096,
  parameter int unsigned MEM_DELAY_CYCLES = 5,
  parameter int unsigned QDEPTH           = 2,
  parameter int unsigned ID_W             = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [31:0]     req_addr,
  input  logic [127:0]    req_wdata,
  input  logic [3:0]      req_wmask,
  input  logic [ID_W-1:0] req_id,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [127:0]    resp_rdata,
  output logic [ID_W-1:0] resp_id,
  output logic            resp_err
);

  localparam int unsigned AW    = $clog2(MEM_WORDS);
  localparam int unsigned LW    = AW - 2;
  localparam int unsigned LINES = MEM_WORDS / 4;
  localparam int unsigned PW    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CNTW  = $clog2(QDEPTH + 1);
  localparam int unsigned DW    = $clog2(MEM_DELAY_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  logic [31:0] data [MEM_WORDS];

  // Request queue storage
  logic            q_write [QDEPTH];
  logic [27:0]     q_line  [QDEPTH];
  logic [127:0]    q_wdata [QDEPTH];
  logic [3:0]      q_wmask [QDEPTH];
  logic [ID_W-1:0] q_id    [QDEPTH];

  state_e          state_q;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0] count_q;
  logic [DW-1:0]   cnt_q;

  // Request currently being served
  logic            act_write_q;
  logic [27:0]     act_line_q;
  logic [127:0]    act_wdata_q;
  logic [3:0]      act_wmask_q;
  logic [ID_W-1:0] act_id_q;

  logic          push, pop, act_err, access, mem_we;
  logic [LW-1:0] li;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^req_addr[3:0];

  // Uses the count from before the edge, so a same-cycle pop never frees a slot.
  assign req_ready = !rst && (count_q < CNTW'(QDEPTH));
  assign push      = req_valid && req_ready;
  // Only pops a queue that was already non-empty, so there is no push-to-pop bypass.
  assign pop       = (state_q == StIdle) && (count_q != '0);
  assign act_err   = {4'd0, act_line_q} >= 32'(LINES);
  assign li        = act_line_q[LW-1:0];
  assign access    = (state_q == StWait) && (cnt_q == DW'(1));
  assign mem_we    = !rst && access && act_write_q && !act_err;

  always_ff @(posedge clk) begin
    if (push) begin
      q_write[wr_ptr_q] <= req_write;
      q_line[wr_ptr_q]  <= req_addr[31:4];
      q_wdata[wr_ptr_q] <= req_wdata;
      q_wmask[wr_ptr_q] <= req_wmask;
      q_id[wr_ptr_q]    <= req_id;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (act_wmask_q[i]) data[{li, 2'(i)}] <= act_wdata_q[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cnt_q       <= '0;
      act_write_q <= 1'b0;
      act_line_q  <= '0;
      act_wdata_q <= '0;
      act_wmask_q <= '0;
      act_id_q    <= '0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_id     <= '0;
      resp_err    <= 1'b0;
    end else begin
      count_q <= count_q + CNTW'(push) - CNTW'(pop);
      if (push) wr_ptr_q <= (wr_ptr_q == PW'(QDEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == PW'(QDEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;

      unique case (state_q)
        StIdle: begin
          if (pop) begin
            act_write_q <= q_write[rd_ptr_q];
            act_line_q  <= q_line[rd_ptr_q];
            act_wdata_q <= q_wdata[rd_ptr_q];
            act_wmask_q <= q_wmask[rd_ptr_q];
            act_id_q    <= q_id[rd_ptr_q];
            cnt_q       <= DW'(MEM_DELAY_CYCLES);
            state_q     <= StWait;
          end
        end
        StWait: begin
          if (access) begin
            resp_valid <= 1'b1;
            resp_id    <= act_id_q;
            resp_err   <= act_err;
            if (act_err || act_write_q) begin
              resp_rdata <= '0;
            end else begin
              resp_rdata <= {data[{li, 2'd3}], data[{li, 2'd2}],
                             data[{li, 2'd1}], data[{li, 2'd0}]};
            end
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StResp: begin
          // rdata and id stay as they are; only valid and err drop on the handshake.
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_line_mem_responder.sv
module tb_line_mem_responder;

  localparam int MEM_WORDS = 4096;
  localparam int DELAY     = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready, req_write;
  logic [31:0]  req_addr;
  logic [127:0] req_wdata;
  logic [3:0]   req_wmask;
  logic [0:0]   req_id;
  logic         resp_valid, resp_ready;
  logic [127:0] resp_rdata;
  logic [0:0]   resp_id;
  logic         resp_err;

  line_mem_responder #(
    .MEM_WORDS(MEM_WORDS), .MEM_DELAY_CYCLES(DELAY), .QDEPTH(2), .ID_W(1)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask), .req_id(req_id),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_id(resp_id), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] rdata;
    logic         id;
    logic         err;
    int           acc;  // edge at which the request was accepted
    int           lat;  // required accept->valid latency, -1 = unchecked
    int           hsg;  // required previous-handshake->valid gap, -1 = unchecked
    int           rg;   // required valid->valid gap, -1 = unchecked
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mdl [int];
  int          n_cmp = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: line L = addr/16; out of range -> error, no memory effect.
  task automatic model(input bit w, input logic [31:0] addr, input logic [127:0] wd,
                       input logic [3:0] wm, input bit apply,
                       output logic [127:0] rd, output bit err);
    int l;
    l   = int'(addr / 16);
    err = (l >= MEM_WORDS / 4);
    rd  = '0;
    if (!err) begin
      for (int i = 0; i < 4; i++) begin
        if (w) begin
          if (apply && wm[i]) mdl[4*l+i] = wd[32*i +: 32];
        end else begin
          rd[32*i +: 32] = mdl.exists(4*l+i) ? mdl[4*l+i] : 32'h0;
        end
      end
    end
  endtask

  // Called off-edge; returns #1 after the accepting edge.
  task automatic send(input bit w, input logic [31:0] addr, input logic [127:0] wd,
                      input logic [3:0] wm, input bit id, input int lat, input int hsg,
                      input int rg, input bit dropped);
    exp_t e;
    bit   err;
    int   n = 0;
    req_valid = 1'b1; req_write = w; req_addr = addr;
    req_wdata = wd; req_wmask = wm; req_id = id;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!req_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL req_accept: got req_ready=0 for 200 cycles, required 1");
      req_valid = 1'b0;
      return;
    end
    e.acc = cyc + 1;
    model(w, addr, wd, wm, !dropped, e.rdata, err);
    e.err = err; e.id = id; e.lat = lat; e.hsg = hsg; e.rg = rg;
    if (!dropped) exp_q.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || resp_valid) && n < 3000) begin
      n++;
      @(negedge clk);
    end
    check("drain_pending", 128'(exp_q.size()), 128'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    int n = 0;
    @(negedge clk);
    while (!resp_valid && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("resp_valid_seen", 128'(resp_valid), 128'(1));
  endtask

  // Monitor: pops the scoreboard on each new response, checks hold stability while stalled.
  bit           prev_valid = 0, prev_hs = 0;
  logic [127:0] hold_rdata;
  logic         hold_id, hold_err;
  int           rise_cyc = 0, hs_cyc = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_valid = 0;
      prev_hs    = 0;
    end else begin
      if (prev_valid && !prev_hs) begin
        check("stall_valid", 128'(resp_valid), 128'(1));
        check("stall_rdata", resp_rdata, hold_rdata);
        check("stall_id", 128'(resp_id), 128'(hold_id));
        check("stall_err", 128'(resp_err), 128'(hold_err));
      end else if (resp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 128'(1), 128'(0));
        end else begin
          e = exp_q.pop_front();
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_id", 128'(resp_id), 128'(e.id));
          check("resp_err", 128'(resp_err), 128'(e.err));
          if (e.lat >= 0) check("latency", 128'(cyc - e.acc), 128'(e.lat));
          if (e.hsg >= 0) check("hs_gap", 128'(cyc - hs_cyc), 128'(e.hsg));
          if (e.rg >= 0)  check("resp_gap", 128'(cyc - rise_cyc), 128'(e.rg));
        end
        rise_cyc   = cyc;
        hold_rdata = resp_rdata;
        hold_id    = resp_id;
        hold_err   = resp_err;
      end
      prev_valid = resp_valid;
      prev_hs    = resp_valid && resp_ready;
      if (prev_hs) hs_cyc = cyc + 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  bit done = 0;

  initial begin
    logic [127:0] wd;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_wmask = '0; req_id = '0; resp_ready = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_req_ready", 128'(req_ready), 128'(0));
    check("rst_valid", 128'(resp_valid), 128'(0));
    check("rst_rdata", resp_rdata, 128'(0));
    check("rst_id", 128'(resp_id), 128'(0));
    check("rst_err", 128'(resp_err), 128'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_req_ready", 128'(req_ready), 128'(1));
    @(posedge clk);
    #1;

    // Initialise the lines in use; line 0x200 gets 1,2,3,4.
    send(1, 32'h2000, {32'd4, 32'd3, 32'd2, 32'd1}, 4'hf, 0, -1, -1, -1, 0);
    for (int l = 1; l < 8; l++) begin
      wd = {$urandom, $urandom, $urandom, $urandom};
      send(1, 32'h2000 + 32'(l * 16), wd, 4'hf, 1, -1, -1, -1, 0);
    end
    wd = {$urandom, $urandom, $urandom, $urandom};
    send(1, 32'h0, wd, 4'hf, 0, -1, -1, -1, 0);
    drain();

    // Read of the preloaded line into an idle responder
    send(0, 32'h2000, '0, 4'h0, 0, DELAY + 1, -1, -1, 0);
    drain();

    // Masked write, then read of the same line back-to-back
    send(1, 32'h2010, {4{32'hAAAAAAAA}}, 4'b0101, 1, -1, -1, -1, 0);
    send(0, 32'h2010, '0, 4'h0, 0, -1, DELAY + 1, -1, 0);
    drain();

    // Three back-to-back requests while stalled: queue fills, then ordered drain
    resp_ready = 1'b0;
    send(0, 32'h2000, '0, 4'h0, 0, DELAY + 1, -1, -1, 0);
    send(0, 32'h2020, '0, 4'h0, 1, -1, DELAY + 1, -1, 0);
    send(0, 32'h2030, '0, 4'h0, 0, -1, DELAY + 1, DELAY + 2, 0);
    @(negedge clk);
    check("req_ready_full", 128'(req_ready), 128'(0));
    wait_valid();
    repeat (3) @(posedge clk);
    #1 resp_ready = 1'b1;
    drain();

    // Out-of-range line: read and write both error; line 0 (alias target) untouched
    send(0, 32'h4000, '0, 4'h0, 1, -1, -1, -1, 0);
    send(1, 32'h4000, {4{32'h5A5A5A5A}}, 4'hf, 0, -1, -1, -1, 0);
    send(0, 32'h0, '0, 4'h0, 1, -1, -1, -1, 0);
    drain();

    // Stall for 10 cycles with a second request queued behind
    resp_ready = 1'b0;
    send(0, 32'h2040, '0, 4'h0, 1, -1, -1, -1, 0);
    send(0, 32'h2050, '0, 4'h0, 0, -1, DELAY + 1, -1, 0);
    wait_valid();
    repeat (10) @(posedge clk);
    #1 resp_ready = 1'b1;
    drain();

    // Reset during the wait of a write: write dropped, outputs cleared, queue empty
    send(1, 32'h2000, {4{32'hDEADBEEF}}, 4'hf, 1, -1, -1, -1, 1);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("mid_rst_req_ready", 128'(req_ready), 128'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_valid", 128'(resp_valid), 128'(0));
    check("post_rst_rdata", resp_rdata, 128'(0));
    check("post_rst_id", 128'(resp_id), 128'(0));
    check("post_rst_err", 128'(resp_err), 128'(0));
    check("post_rst_req_ready", 128'(req_ready), 128'(1));
    @(posedge clk);
    #1;
    send(0, 32'h2000, '0, 4'h0, 0, DELAY + 1, -1, -1, 0);
    drain();

    // Random traffic with random back-pressure
    fork
      begin
        for (int k = 0; k < 150; k++) begin
          int          r;
          logic [31:0] a;
          logic [27:0] l;
          r = $urandom_range(0, 9);
          if (r < 8)       l = 28'h200 + 28'(r);
          else if (r == 8) l = 28'h0;
          else             l = 28'($urandom_range(1024, 32'h0FFFFFFF));
          a = {l, 4'($urandom)};
          send(1'($urandom), a, {$urandom, $urandom, $urandom, $urandom}, 4'($urandom),
               1'($urandom), -1, -1, -1, 0);
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
          end
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 resp_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    resp_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
